// File: rtl/display_timings.sv
// Free-running pixel/line timing generator: coordinates, syncs, data enable and frame/line strobes.
// Optional frame counter port o_frame_cnt is built when DISPLAY_TIMINGS_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
module display_timings #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_POL  = 0,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_POL  = 0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst_n,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame,
  output logic        o_line,
  output logic [15:0] o_x,
  output logic [15:0] o_y
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_check
      $error("display_timings: H_TOTAL/V_TOTAL must not exceed 65535");
    end
  endgenerate

  localparam logic [15:0] L_H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] L_V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] L_H_RES    = 16'(H_RES);
  localparam logic [15:0] L_V_RES    = 16'(V_RES);
  localparam logic [15:0] L_HS_START = 16'(H_RES + H_FP);
  localparam logic [15:0] L_HS_END   = 16'(H_RES + H_FP + H_SYNC);
  localparam logic [15:0] L_VS_START = 16'(V_RES + V_FP);
  localparam logic [15:0] L_VS_END   = 16'(V_RES + V_FP + V_SYNC);
  localparam logic        L_HS_ACT   = (H_POL != 0);
  localparam logic        L_VS_ACT   = (V_POL != 0);

  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_frame;
  logic        r_line;

  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic        w_x_wrap;

  // Outputs are registered from the next-state coordinates so every output
  // describes the same pixel as o_x/o_y with no relative skew.
  assign w_x_wrap = (r_x == L_H_LAST);
  assign w_x_nxt  = w_x_wrap ? 16'd0 : r_x + 16'd1;
  assign w_y_nxt  = !w_x_wrap ? r_y : ((r_y == L_V_LAST) ? 16'd0 : r_y + 16'd1);

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x     <= L_H_LAST;
      r_y     <= L_V_LAST;
      r_hs    <= !L_HS_ACT;
      r_vs    <= !L_VS_ACT;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
      r_line  <= 1'b0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_hs    <= ((w_x_nxt >= L_HS_START) && (w_x_nxt < L_HS_END)) ? L_HS_ACT : !L_HS_ACT;
      r_vs    <= ((w_y_nxt >= L_VS_START) && (w_y_nxt < L_VS_END)) ? L_VS_ACT : !L_VS_ACT;
      r_de    <= (w_x_nxt < L_H_RES) && (w_y_nxt < L_V_RES);
      r_frame <= (w_x_nxt == 16'd0) && (w_y_nxt == 16'd0);
      r_line  <= (w_x_nxt == 16'd0);
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_hs    = r_hs;
  assign o_vs    = r_vs;
  assign o_de    = r_de;
  assign o_frame = r_frame;
  assign o_line  = r_line;

`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts on the edge that raises o_frame, so the first frame reads 1.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if ((w_x_nxt == 16'd0) && (w_y_nxt == 16'd0)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule
